iob_soc_sut_rst_ctrl: RTL and testbench
=======================================

// Module: iob_soc_sut_rst_ctrl
// PURPOSE
//  Reset controller directly upstream of the iob_soc_sut core in the FPGA wrapper.
//  Takes the board reset (resetn), an asynchronous user pushbutton and the core's trap_o.
//  Produces a glitch-free, stretched, active-high system reset for the core's arst_i.
//  Asserts asynchronously, deasserts synchronously, and records the cause of the last reset.
// PARAMETERS
//  SYNC_STAGES  2        synchronizer depth for reset release and pushbutton (>=2)
//  DEBOUNCE_W   16       debounce counter width; stable time = 2^DEBOUNCE_W-1 cycles
//  HOLD_W       16       hold counter width
//  HOLD_CNT     16'hFFFF reload value of hold counter (reset stretch, HOLD_CNT+1 cycles)
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  board reset, asynchronous, active-low
//  btn_rst_i    in   1  user reset button, active-high, asynchronous to clk, bouncy
//  trap_i       in   1  trap_o from iob_soc_sut, synchronous to clk
//  sys_rst_o    out  1  system reset to iob_soc_sut arst_i, active-high, registered
//  rst_done_o   out  1  one-cycle pulse on the edge sys_rst_o falls
//  rst_cause_o  out  2  last reset cause: 00 board/power, 01 button, 10 trap restart
// BEHAVIOUR
//  resetn low (async):
//   - release sync chain=0, FSM=HOLD, hold cnt=HOLD_CNT
//   - debounce cnt=0, btn_stable=0, button sync chain=0
//   - sys_rst_o=1, rst_done_o=0, rst_cause_o=00
//  Release sync: SYNC_STAGES flops shift in 1 after resetn rises; rst_sync = last stage.
//  FSM states: HOLD, RUN.
//  HOLD:
//   - rst_sync=0: hold cnt frozen at HOLD_CNT.
//   - rst_sync=1 and btn_stable=1: hold cnt reloaded to HOLD_CNT (reset held while pressed).
//   - otherwise hold cnt decrements by 1 per cycle.
//   - on the edge with hold cnt==0: FSM->RUN, sys_rst_o<=0, rst_done_o<=1 for that one cycle.
//   - Latency: sys_rst_o falls HOLD_CNT+1 edges after the first edge with rst_sync=1.
//   - trap_i and btn_stable rising edges are ignored in HOLD.
//  RUN:
//   - btn_stable rising edge: FSM->HOLD, cnt=HOLD_CNT, sys_rst_o<=1, cause<=01.
//   - trap restart (feature below): FSM->HOLD, cnt=HOLD_CNT, sys_rst_o<=1, cause<=10.
//   - Button and trap in the same cycle: button wins, cause=01.
//  Button debounce:
//   - btn_rst_i passes through a SYNC_STAGES synchronizer -> btn_s.
//   - btn_s==btn_stable: debounce cnt=0.
//   - btn_s!=btn_stable: cnt increments; at all-ones, btn_stable<=btn_s and cnt<=0 (no wrap).
//   - Stable edge = first cycle btn_stable changes.
//  Other rules:
//   - rst_cause_o holds its value until the next reset event; resetn low always forces 00.
//   - All outputs come straight from flops; no combinational path from any input to sys_rst_o
//     except the async clear by resetn.
//   - resetn asserted mid-HOLD or mid-debounce restarts everything as above.
// CONFIGURATION
//  IOB_SOC_SUT_TRAP_RESTART_EN
//   - defined: a trap_i rising edge (trap_i=1, previous-cycle trap_i=0) in RUN triggers a
//     restart with cause 10; the trap_i delay flop is cleared by resetn and while in HOLD.
//   - undefined: trap_i is ignored, no trap flop is instantiated, cause 10 is never produced.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_W=3, HOLD_CNT=8)
//  1 Power-on:
//    resetn low 5 cycles, then high -> sys_rst_o=1 throughout, falls 2+9 edges after release;
//    rst_done_o high exactly 1 cycle; rst_cause_o=00.
//  2 Bounce rejection:
//    in RUN, btn_rst_i toggles every 3 cycles for 30 cycles -> sys_rst_o stays 0.
//    btn_rst_i then held 1 -> sys_rst_o rises 2+7+1 edges after the level change, cause=01.
//  3 Button hold:
//    btn_rst_i high 100 cycles, then low -> sys_rst_o stays 1 while the button is stable high;
//    falls 9 edges after btn_stable returns to 0; one rst_done_o pulse.
//  4 Trap restart:
//    macro defined: 1-cycle trap_i pulse in RUN -> sys_rst_o=1 next edge, cause=10, low 9 edges later.
//    macro undefined: same stimulus -> no change.
//  5 Mid-HOLD reset:
//    assert resetn low when hold cnt=4 after a button reset -> cause=00 immediately;
//    full power-on sequence repeats after release.
//  6 Simultaneous events (macro defined):
//    btn_stable rising edge and trap_i rising edge on the same edge -> cause=01, one hold period.

Source files
------------

// File: rtl/iob_soc_sut_rst_ctrl.sv
// iob_soc_sut_rst_ctrl
//   Reset controller in front of the iob_soc_sut core. It combines the board
//   reset, a debounced user pushbutton and (optionally) a trap restart into
//   one stretched, active-high system reset. The reset asserts asynchronously
//   and releases synchronously. The cause of the last reset is recorded.
//   Optional feature macro: IOB_SOC_SUT_TRAP_RESTART_EN. When it is defined, a
//   rising edge on trap_i while running restarts the core with cause 2'b10.
module iob_soc_sut_rst_ctrl #(
  parameter int                SYNC_STAGES = 2,        // must be >= 2
  parameter int                DEBOUNCE_W  = 16,
  parameter int                HOLD_W      = 16,
  parameter logic [HOLD_W-1:0] HOLD_CNT    = 16'hFFFF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btn_rst_i,
  input  logic       trap_i,
  output logic       sys_rst_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  localparam logic [1:0] CAUSE_BOARD  = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_TRAP   = 2'b10;

  // The debounce counter never stores all-ones. The increment that would
  // reach all-ones updates btn_stable instead. The input must therefore
  // disagree with btn_stable for 2^DEBOUNCE_W-1 consecutive cycles.
  localparam logic [DEBOUNCE_W-1:0] DB_LAST = {{(DEBOUNCE_W-1){1'b1}}, 1'b0};

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [HOLD_W-1:0]       r_hold_cnt;
  logic [HOLD_W-1:0]       w_hold_next;
  logic                    r_sys_rst;
  logic                    w_sys_rst_next;
  logic                    r_done;
  logic                    w_done_next;
  logic [1:0]              r_cause;
  logic [1:0]              w_cause_next;

  logic [SYNC_STAGES-1:0]  r_rel_sync;
  logic [SYNC_STAGES-1:0]  r_btn_sync;
  logic [DEBOUNCE_W-1:0]   r_db_cnt;
  logic                    r_btn_stable;
  logic                    r_btn_stable_q;

  logic                    w_rst_sync;
  logic                    w_btn_s;
  logic                    w_btn_rise;
  logic                    w_trap_rise;

  assign w_rst_sync = r_rel_sync[SYNC_STAGES-1];
  assign w_btn_s    = r_btn_sync[SYNC_STAGES-1];
  assign w_btn_rise = r_btn_stable & ~r_btn_stable_q;

  // Release synchronizer: a shift register that fills with ones after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rel_sync <= '0;
    else         r_rel_sync <= {r_rel_sync[SYNC_STAGES-2:0], 1'b1};
  end

  // Pushbutton synchronizer, because btn_rst_i is asynchronous to clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_btn_sync <= '0;
    else         r_btn_sync <= {r_btn_sync[SYNC_STAGES-2:0], btn_rst_i};
  end

  // Debounce: btn_stable follows btn_s only after a long unbroken disagreement.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_db_cnt       <= '0;
      r_btn_stable   <= 1'b0;
      r_btn_stable_q <= 1'b0;
    end else begin
      r_btn_stable_q <= r_btn_stable;
      if (w_btn_s == r_btn_stable) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_stable <= w_btn_s;
        r_db_cnt     <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DEBOUNCE_W'(1);
      end
    end
  end

`ifdef IOB_SOC_SUT_TRAP_RESTART_EN
  logic r_trap_q;

  // Trap edge detector. It is cleared during HOLD, so a trap that stays high
  // across a restart produces a new edge once the core runs again.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_trap_q <= 1'b0;
    else         r_trap_q <= (r_state == ST_RUN) ? trap_i : 1'b0;
  end

  assign w_trap_rise = trap_i & ~r_trap_q;
`else
  logic w_unused_trap;
  assign w_unused_trap = trap_i;
  assign w_trap_rise   = 1'b0;
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_HOLD;
      r_hold_cnt <= HOLD_CNT;
      r_sys_rst  <= 1'b1;
      r_done     <= 1'b0;
      r_cause    <= CAUSE_BOARD;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_sys_rst  <= w_sys_rst_next;
      r_done     <= w_done_next;
      r_cause    <= w_cause_next;
    end
  end

  // Next-state logic: stretch the reset in HOLD and watch for restart events in RUN.
  always_comb begin
    w_state_next   = r_state;
    w_hold_next    = r_hold_cnt;
    w_sys_rst_next = r_sys_rst;
    w_done_next    = 1'b0;
    w_cause_next   = r_cause;
    case (r_state)
      ST_HOLD: begin
        // Button edges and trap edges are ignored here. A pressed button
        // keeps the counter reloaded until it is released.
        if (!w_rst_sync || r_btn_stable) begin
          w_hold_next = HOLD_CNT;
        end else if (r_hold_cnt == '0) begin
          w_state_next   = ST_RUN;
          w_sys_rst_next = 1'b0;
          w_done_next    = 1'b1;
        end else begin
          w_hold_next = r_hold_cnt - HOLD_W'(1);
        end
      end
      ST_RUN: begin
        // If both events occur on the same edge, the button has priority.
        if (w_btn_rise) begin
          w_state_next   = ST_HOLD;
          w_hold_next    = HOLD_CNT;
          w_sys_rst_next = 1'b1;
          w_cause_next   = CAUSE_BUTTON;
        end else if (w_trap_rise) begin
          w_state_next   = ST_HOLD;
          w_hold_next    = HOLD_CNT;
          w_sys_rst_next = 1'b1;
          w_cause_next   = CAUSE_TRAP;
        end
      end
      default: begin
        w_state_next   = ST_HOLD;
        w_hold_next    = HOLD_CNT;
        w_sys_rst_next = 1'b1;
      end
    endcase
  end

  assign sys_rst_o   = r_sys_rst;
  assign rst_done_o  = r_done;
  assign rst_cause_o = r_cause;

endmodule

// File: tb/tb_iob_soc_sut_rst_ctrl.sv
// tb_iob_soc_sut_rst_ctrl
//   Directed and random stimulus for iob_soc_sut_rst_ctrl (SYNC_STAGES=2,
//   DEBOUNCE_W=3, HOLD_CNT=8). A timeline model predicts the outputs on every
//   edge:
//   - The button filter is a window of the last 7 synchronized samples.
//   - The reset stretch is an absolute release edge number.
//   Key latencies are also compared against hand-derived constants.
module tb_iob_soc_sut_rst_ctrl;

  localparam int          SS         = 2;
  localparam int          DW         = 3;
  localparam logic [15:0] HC         = 16'd8;
  localparam int          DB_RUN     = (1 << DW) - 1;  // 7 disagreeing samples
  localparam int          HOLD_EDGES = 9;              // HOLD_CNT + 1
`ifdef IOB_SOC_SUT_TRAP_RESTART_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       btn_rst_i = 1'b0;
  logic       trap_i = 1'b0;
  logic       sys_rst_o;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;

  iob_soc_sut_rst_ctrl #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_W (DW),
    .HOLD_W     (16),
    .HOLD_CNT   (HC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_rst_i  (btn_rst_i),
    .trap_i     (trap_i),
    .sys_rst_o  (sys_rst_o),
    .rst_done_o (rst_done_o),
    .rst_cause_o(rst_cause_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state.
  int         rel_edges;     // edges seen with resetn high since release
  bit         in_q[$];       // raw button samples of the last SS edges
  bit         bs_q[$];       // synchronized button samples of the last DB_RUN edges
  bit         stable, stable_prev, trap_prev;
  bit         in_rst, done;
  int         release_edge;
  logic [1:0] cause;

  task automatic model_reset();
    rel_edges    = 0;
    in_q.delete();
    bs_q.delete();
    stable       = 1'b0;
    stable_prev  = 1'b0;
    trap_prev    = 1'b0;
    in_rst       = 1'b1;
    done         = 1'b0;
    release_edge = -1;
    cause        = 2'b00;
  endtask

  task automatic model_edge();
    bit rst_sync, btn_s, win_all, new_stable, was_run;
    if (!resetn) begin
      model_reset();
      return;
    end
    rst_sync = (rel_edges >= SS);
    btn_s    = (in_q.size() == SS) ? in_q[0] : 1'b0;
    in_q.push_back(btn_rst_i);
    if (in_q.size() > SS) void'(in_q.pop_front());
    bs_q.push_back(btn_s);
    if (bs_q.size() > DB_RUN) void'(bs_q.pop_front());
    win_all = (bs_q.size() == DB_RUN);
    foreach (bs_q[i]) if (bs_q[i] == stable) win_all = 1'b0;
    new_stable = win_all ? ~stable : stable;
    was_run = ~in_rst;
    done = 1'b0;
    if (in_rst) begin
      if (!rst_sync || stable) begin
        release_edge = cyc + HOLD_EDGES;
      end else if (cyc == release_edge) begin
        in_rst = 1'b0;
        done   = 1'b1;
      end
    end else begin
      if (stable && !stable_prev) begin
        in_rst = 1'b1; cause = 2'b01; release_edge = cyc + HOLD_EDGES;
      end else if (TRAP_EN && trap_i && !trap_prev) begin
        in_rst = 1'b1; cause = 2'b10; release_edge = cyc + HOLD_EDGES;
      end
    end
    trap_prev   = was_run ? trap_i : 1'b0;
    stable_prev = stable;
    stable      = new_stable;
    rel_edges++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".sys_rst"}, {31'd0, sys_rst_o}, {31'd0, in_rst});
    chk({tag, ".done"},    {31'd0, rst_done_o}, {31'd0, done});
    chk({tag, ".cause"},   {30'd0, rst_cause_o}, {30'd0, cause});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic wait_sys(input logic val, input int bound, output int n);
    n = 0;
    while (sys_rst_o !== val && n < bound) begin
      tick("wait");
      n++;
    end
  endtask

  task automatic async_reset(input string tag);
    resetn = 1'b0;
    model_reset();
    #1;
    check_all(tag);
  endtask

  int n, kind, p, len;

  initial begin
    model_reset();
    #1;

    // 1 Power-on sequence.
    async_reset("por_async");
    repeat (5) tick("por_low");
    resetn = 1'b1;
    wait_sys(1'b0, 40, n);
    chk("por_len", n, 2 + HOLD_EDGES);
    chk("por_done", {31'd0, rst_done_o}, 1);
    chk("por_cause", {30'd0, rst_cause_o}, 0);
    tick("por_after");
    chk("por_done_1cyc", {31'd0, rst_done_o}, 0);
    $display("step power_on release_edges=%0d", n);

    // 2 Bounce rejection, followed by a clean press.
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn_rst_i = ~btn_rst_i;
      tick("bounce");
    end
    chk("bounce_sys", {31'd0, sys_rst_o}, 0);
    btn_rst_i = 1'b0;
    repeat (4) tick("bounce_quiet");
    btn_rst_i = 1'b1;
    wait_sys(1'b1, 40, n);
    chk("btn_rise_lat", n, 2 + DB_RUN + 1);
    chk("btn_cause", {30'd0, rst_cause_o}, 1);
    $display("step bounce_then_press rise_edges=%0d", n);

    // 3 Long press; the reset stretch starts only after the release.
    repeat (90) tick("btn_hold");
    chk("btn_hold_sys", {31'd0, sys_rst_o}, 1);
    btn_rst_i = 1'b0;
    wait_sys(1'b0, 60, n);
    chk("btn_release_lat", n, 2 + DB_RUN + HOLD_EDGES);
    chk("btn_release_done", {31'd0, rst_done_o}, 1);
    repeat (3) tick("btn_after");
    $display("step button_hold fall_edges=%0d", n);

    // 4 Single-cycle trap pulse.
    trap_i = 1'b1;
    tick("trap");
    trap_i = 1'b0;
`ifdef IOB_SOC_SUT_TRAP_RESTART_EN
    chk("trap_sys", {31'd0, sys_rst_o}, 1);
    chk("trap_cause", {30'd0, rst_cause_o}, 2);
    wait_sys(1'b0, 30, n);
    chk("trap_len", n, HOLD_EDGES);
`else
    chk("trap_ignored", {31'd0, sys_rst_o}, 0);
    repeat (12) tick("trap_idle");
    chk("trap_cause_kept", {30'd0, rst_cause_o}, 1);
`endif
    repeat (3) tick("trap_after");
    $display("step trap_pulse");

    // 5 Board reset in the middle of a button-initiated HOLD.
    btn_rst_i = 1'b1;
    wait_sys(1'b1, 40, n);
    btn_rst_i = 1'b0;
    n = 0;
    while (!(in_rst && release_edge - cyc == 5) && n < 60) begin
      tick("mid_wait");
      n++;
    end
    chk("mid_reached", {31'd0, (n < 60)}, 1);
    chk("mid_pre_cause", {30'd0, rst_cause_o}, 1);
    async_reset("mid_async");
    chk("mid_cause", {30'd0, rst_cause_o}, 0);
    repeat (3) tick("mid_low");
    resetn = 1'b1;
    wait_sys(1'b0, 40, n);
    chk("mid_por_len", n, 2 + HOLD_EDGES);
    repeat (3) tick("mid_after");
    $display("step mid_hold_reset fall_edges=%0d", n);

    // 6 Stable button edge and trap edge on the same clock edge.
    btn_rst_i = 1'b1;
    repeat (2 + DB_RUN) tick("simul_btn");
    trap_i = 1'b1;
    tick("simul_edge");
    trap_i = 1'b0;
    chk("simul_sys", {31'd0, sys_rst_o}, 1);
    chk("simul_cause", {30'd0, rst_cause_o}, 1);
    btn_rst_i = 1'b0;
    wait_sys(1'b0, 60, n);
    chk("simul_len", n, 2 + DB_RUN + HOLD_EDGES);
    repeat (12) tick("simul_after");
    chk("simul_single", {31'd0, sys_rst_o}, 0);
    $display("step simultaneous fall_edges=%0d", n);

    // Random transactions, checked on every edge against the model.
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 4));
      p    = int'($urandom_range(1, 9));
      len  = int'($urandom_range(1, 25));
      case (kind)
        0: for (int i = 0; i < len + 6; i++) begin
             if (i % p == 0) btn_rst_i = ~btn_rst_i;
             tick("rnd_bounce");
           end
        1: begin
             btn_rst_i = 1'b1;
             repeat (len) tick("rnd_press");
             btn_rst_i = 1'b0;
           end
        2: begin
             trap_i = 1'b1;
             repeat (p % 3 + 1) tick("rnd_trap");
             trap_i = 1'b0;
           end
        3: repeat (len) tick("rnd_idle");
        default: begin
             async_reset("rnd_async");
             repeat (p % 3 + 1) tick("rnd_low");
             resetn = 1'b1;
           end
      endcase
      $display("tx %0d kind=%0d p=%0d len=%0d sys_rst=%b cause=%0d", t, kind, p, len, sys_rst_o, rst_cause_o);
    end

    btn_rst_i = 1'b0;
    trap_i    = 1'b0;
    repeat (40) tick("drain");
    chk("drain_sys", {31'd0, sys_rst_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
